link_controller: RTL and testbench

LINK_CONTROLLER -- requirements
Module: link_controller

---
 rtl/link_controller_if.sv | 19 +
 rtl/link_controller.sv | 110 +++++++++++
 tb/tb_link_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/link_controller_if.sv
// link_controller_if: transceiver bus between the link controller and the transceiver
// Signals:
//   tx_enable  - controller requests transmission of data_in
//   data_in    - frame presented to the transceiver
//   irq_tx     - transceiver level interrupt, frame sent
//   irq_rx     - transceiver level interrupt, frame received on data_out
//   data_out   - frame received by the transceiver
// Modports: master (controller side), slave (transceiver side)
interface link_controller_if #(
   parameter int FRAME_SIZE = 16
) ();
   logic                  tx_enable;
   logic [FRAME_SIZE-1:0] data_in;
   logic                  irq_tx;
   logic                  irq_rx;
   logic [FRAME_SIZE-1:0] data_out;
   modport master (output tx_enable, data_in, input irq_tx, irq_rx, data_out);
   modport slave (input tx_enable, data_in, output irq_tx, irq_rx, data_out);
endinterface

// File: rtl/link_controller.sv
// link_controller: two-requester round-robin frame sender with ack matching, timeout retry and receive path
// Ports:
//   clock              - sole clock, rising edge
//   reset              - asynchronous active-low reset
//   req_0/req_1        - requester transmit requests
//   data_0/data_1      - requester frames
//   done_0/done_1      - one-cycle pulse, frame acknowledged
//   fail_0/fail_1      - one-cycle pulse, retries exhausted
//   busy               - controller outside IDLE
//   xcvr               - transceiver bus (master side)
//   rx_valid/rx_data   - pulse and held value of the last non-ack received frame
module link_controller #(
   parameter int         FRAME_SIZE = 16,
   parameter int         TIMEOUT    = 255,
   parameter int         MAX_RETRY  = 3,
   parameter logic [7:0] ACK_TAG    = 8'hAC
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_0,
   input  logic                  req_1,
   input  logic [FRAME_SIZE-1:0] data_0,
   input  logic [FRAME_SIZE-1:0] data_1,
   output logic                  done_0,
   output logic                  done_1,
   output logic                  fail_0,
   output logic                  fail_1,
   output logic                  busy,
   link_controller_if.master     xcvr,
   output logic                  rx_valid,
   output logic [FRAME_SIZE-1:0] rx_data
);
   localparam logic [7:0] TO = 8'(TIMEOUT);
   localparam logic [7:0] MR = 8'(MAX_RETRY);
   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, DONE, FAIL} state_t;
   state_t     state;
   logic       last;
   logic       gnt;
   logic       irq_rx_q;
   logic [7:0] timer;
   logic [7:0] retry;
   logic       rx_edge;
   logic       is_ack;
   logic       ack_match;
   logic       pick;
   assign rx_edge   = xcvr.irq_rx & ~irq_rx_q;
   assign is_ack    = xcvr.data_out[15:8] == ACK_TAG;
   assign ack_match = rx_edge & is_ack & (xcvr.data_out[7:0] == xcvr.data_in[7:0]);
   // on a tie the requester not granted last wins; otherwise whoever is asking
   assign pick      = (req_0 & req_1) ? ~last : req_1;
   assign busy      = state != IDLE;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state          <= IDLE;
         last           <= 1'b1;
         gnt            <= 1'b0;
         irq_rx_q       <= 1'b0;
         timer          <= '0;
         retry          <= '0;
         xcvr.tx_enable <= 1'b0;
         xcvr.data_in   <= '0;
         done_0         <= 1'b0;
         done_1         <= 1'b0;
         fail_0         <= 1'b0;
         fail_1         <= 1'b0;
         rx_valid       <= 1'b0;
         rx_data        <= '0;
      end else begin
         irq_rx_q <= xcvr.irq_rx;
         // ack-tagged frames never reach the receive port, matched or not
         rx_valid <= rx_edge & ~is_ack;
         if (rx_edge & ~is_ack) rx_data <= xcvr.data_out;
         done_0 <= 1'b0;
         done_1 <= 1'b0;
         fail_0 <= 1'b0;
         fail_1 <= 1'b0;
         case (state)
            IDLE: if (req_0 | req_1) begin
               state          <= SEND;
               gnt            <= pick;
               last           <= pick;
               xcvr.data_in   <= pick ? data_1 : data_0;
               retry          <= '0;
               xcvr.tx_enable <= 1'b1;
            end
            SEND: if (xcvr.irq_tx) begin
               state          <= WAIT_ACK;
               xcvr.tx_enable <= 1'b0;
               timer          <= '0;
            end
            // ack is checked before the timeout so a match on the last cycle completes
            WAIT_ACK: if (ack_match) begin
               state  <= DONE;
               done_0 <= ~gnt;
               done_1 <= gnt;
            end else if (timer == TO) begin
               if (retry < MR) begin
                  retry          <= retry + 8'd1;
                  state          <= SEND;
                  xcvr.tx_enable <= 1'b1;
               end else begin
                  state  <= FAIL;
                  fail_0 <= ~gnt;
                  fail_1 <= gnt;
               end
            end else if (timer != 8'hFF) timer <= timer + 8'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_link_controller.sv
// tb_link_controller: scoreboard bench for link_controller with directed transceiver stimulus
module tb_link_controller;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_0 = 1'b0;
   logic        req_1 = 1'b0;
   logic [15:0] data_0 = '0;
   logic [15:0] data_1 = '0;
   logic        irq_tx = 1'b0;
   logic        irq_rx = 1'b0;
   logic [15:0] data_out = '0;
   logic        a_done_0, a_done_1, a_fail_0, a_fail_1, a_busy, a_rx_valid;
   logic [15:0] a_rx_data;
   logic        done_0, done_1, fail_0, fail_1, busy, rx_valid;
   logic [15:0] rx_data;
   int          checks = 0;
   int          errors = 0;
   int          sends = 0;
   logic        tx_prev = 1'b0;
   logic [19:0] expq[$];
   link_controller_if #(.FRAME_SIZE(16)) xa ();
   link_controller_if #(.FRAME_SIZE(16)) xb ();
   assign xa.irq_tx   = irq_tx;
   assign xa.irq_rx   = irq_rx;
   assign xa.data_out = data_out;
   assign xb.irq_tx   = irq_tx;
   assign xb.irq_rx   = irq_rx;
   assign xb.data_out = data_out;
   always #5 clock = ~clock;
   link_controller u_a (
      .clock(clock), .reset(reset), .req_0(req_0), .req_1(req_1), .data_0(data_0), .data_1(data_1),
      .done_0(a_done_0), .done_1(a_done_1), .fail_0(a_fail_0), .fail_1(a_fail_1), .busy(a_busy),
      .xcvr(xa), .rx_valid(a_rx_valid), .rx_data(a_rx_data)
   );
   link_controller #(.TIMEOUT(4), .MAX_RETRY(3)) u_b (
      .clock(clock), .reset(reset), .req_0(req_0), .req_1(req_1), .data_0(data_0), .data_1(data_1),
      .done_0(done_0), .done_1(done_1), .fail_0(fail_0), .fail_1(fail_1), .busy(busy),
      .xcvr(xb), .rx_valid(rx_valid), .rx_data(rx_data)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask
   // event codes: 1 done_0, 2 done_1, 3 fail_0, 4 fail_1, 5 rx_valid with data
   task automatic post(input logic [19:0] act);
      if (expq.size() == 0) check("unexpected_event", 32'(act), 32'h0);
      else check("event", 32'(act), 32'(expq.pop_front()));
   endtask
   always @(negedge clock) begin
      if (xb.tx_enable && !tx_prev) sends <= sends + 1;
      tx_prev <= xb.tx_enable;
      if (done_0) post({4'd1, 16'h0});
      if (done_1) post({4'd2, 16'h0});
      if (fail_0) post({4'd3, 16'h0});
      if (fail_1) post({4'd4, 16'h0});
      if (rx_valid) post({4'd5, rx_data});
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic wait_tx(input logic level);
      int i;
      i = 0;
      @(negedge clock);
      while (xb.tx_enable !== level && i < 40) begin
         @(negedge clock);
         i++;
      end
      if (xb.tx_enable !== level) check("wait_tx", {31'd0, xb.tx_enable}, {31'd0, level});
      @(posedge clock);
      #1;
   endtask
   task automatic send_phase(input logic [15:0] frame);
      wait_tx(1'b1);
      check("data_in", 32'(xb.data_in), 32'(frame));
      irq_tx = 1'b1;
      wait_tx(1'b0);
      irq_tx = 1'b0;
   endtask
   task automatic rx_frame(input logic [15:0] d);
      irq_rx   = 1'b1;
      data_out = d;
      tick(1);
      irq_rx = 1'b0;
      tick(1);
   endtask
   initial begin
      logic [15:0] mask;
      logic [15:0] a_din;
      int d0, f0, dcyc, s0;
      tick(3);
      check("rst_tx", {31'd0, xb.tx_enable}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_data_in", 32'(xb.data_in), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_pulses", {27'd0, done_0, done_1, fail_0, fail_1, rx_valid}, 32'd0);
      reset = 1'b1;
      tick(1);
      // single send on the default-parameter instance
      mask = '0; d0 = 0; f0 = 0; dcyc = -1; a_din = '0;
      req_0 = 1'b1;
      data_0 = 16'h5045;
      for (int c = 0; c < 15; c++) begin
         @(negedge clock);
         if (xa.tx_enable) mask[c] = 1'b1;
         if (a_done_0) begin d0++; dcyc = c; end
         if (a_fail_0) f0++;
         if (c == 1) a_din = xa.data_in;
         @(posedge clock);
         #1;
         if (c + 1 == 1) req_0 = 1'b0;
         if (c + 1 == 4) irq_tx = 1'b1;
         if (c + 1 == 5) irq_tx = 1'b0;
         if (c + 1 == 10) begin irq_rx = 1'b1; data_out = 16'hAC45; end
         if (c + 1 == 11) irq_rx = 1'b0;
      end
      check("single_tx_cycles", 32'(mask), 32'h001E);
      check("single_data_in", 32'(a_din), 32'h5045);
      check("single_done_count", 32'(d0), 32'd1);
      check("single_done_cycle", 32'(dcyc), 32'd11);
      check("single_fail_count", 32'(f0), 32'd0);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      // tie: grant order 0,1,0,1
      expq.push_back({4'd1, 16'h0});
      expq.push_back({4'd2, 16'h0});
      expq.push_back({4'd1, 16'h0});
      expq.push_back({4'd2, 16'h0});
      req_0 = 1'b1; req_1 = 1'b1;
      data_0 = 16'h0011; data_1 = 16'h0122;
      for (int i = 0; i < 4; i++) begin
         send_phase(i % 2 == 1 ? 16'h0122 : 16'h0011);
         rx_frame(i % 2 == 1 ? 16'hAC22 : 16'hAC11);
      end
      req_0 = 1'b0; req_1 = 1'b0;
      tick(3);
      check("tie_idle_busy", {31'd0, busy}, 32'd0);
      // no ack: four sends then fail_0
      s0 = sends;
      expq.push_back({4'd3, 16'h0});
      req_0 = 1'b1;
      data_0 = 16'h5045;
      for (int i = 0; i < 4; i++) begin
         send_phase(16'h5045);
         req_0 = 1'b0;
      end
      tick(12);
      check("noack_sends", 32'(sends - s0), 32'd4);
      check("noack_busy", {31'd0, busy}, 32'd0);
      // mismatched ack discarded, retry, then data frame and real ack
      s0 = sends;
      expq.push_back({4'd5, 16'h1234});
      expq.push_back({4'd1, 16'h0});
      req_0 = 1'b1;
      send_phase(16'h5045);
      req_0 = 1'b0;
      rx_frame(16'hAC00);
      send_phase(16'h5045);
      rx_frame(16'h1234);
      rx_frame(16'hAC45);
      tick(3);
      check("badack_sends", 32'(sends - s0), 32'd2);
      check("badack_rx_data", 32'(rx_data), 32'h1234);
      // frames in IDLE: data frame reported, ack frame dropped
      expq.push_back({4'd5, 16'h00AC});
      rx_frame(16'h00AC);
      rx_frame(16'hAC45);
      tick(2);
      check("idle_rx_hold", 32'(rx_data), 32'h00AC);
      // ack on the timeout cycle wins
      s0 = sends;
      expq.push_back({4'd1, 16'h0});
      req_0 = 1'b1;
      send_phase(16'h5045);
      req_0 = 1'b0;
      tick(3);
      rx_frame(16'hAC45);
      tick(6);
      check("edge_ack_sends", 32'(sends - s0), 32'd1);
      // reset while in SEND
      req_1 = 1'b1;
      data_1 = 16'h7733;
      wait_tx(1'b1);
      reset = 1'b0;
      #1;
      check("midrst_tx", {31'd0, xb.tx_enable}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      req_1 = 1'b0;
      tick(2);
      check("midrst_pulses", {27'd0, done_0, done_1, fail_0, fail_1, rx_valid}, 32'd0);
      reset = 1'b1;
      tick(1);
      // operation resumes after reset release
      expq.push_back({4'd2, 16'h0});
      req_1 = 1'b1;
      send_phase(16'h7733);
      req_1 = 1'b0;
      rx_frame(16'hAC33);
      tick(4);
      check("queue_empty", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
